cci_rd_arbiter: RTL



---
 rtl/cci_rd_arbiter_pkg.sv | 36 +++
 rtl/cci_rd_arbiter_if.sv | 42 ++++
 rtl/cci_rd_arbiter_rr_priority_pick.sv | 30 +++
 rtl/cci_rd_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cci_rd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cci_rd_arb_pkg: width derivations and mdata pack/unpack helpers       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cci_rd_arb_pkg;

  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  function automatic int tag_width(input int num_req, input int mdata_w);
    return mdata_w - id_width(num_req);
  endfunction

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  // Helpers work on a 32-bit carrier; callers cast to the real mdata width.
  function automatic logic [31:0] mdata_pack(input logic [31:0] id, input logic [31:0] tag,
                                             input int tag_w);
    return (id << tag_w) | (tag & ((32'd1 << tag_w) - 32'd1));
  endfunction

  function automatic logic [31:0] mdata_id(input logic [31:0] mdata, input int mdata_w,
                                           input int id_w);
    return (mdata >> (mdata_w - id_w)) & ((32'd1 << id_w) - 32'd1);
  endfunction

  function automatic logic [31:0] mdata_tag(input logic [31:0] mdata, input int tag_w);
    return mdata & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cci_rd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cci_rd_arbiter_if: requester, host request and host response bundle  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface cci_rd_arbiter_if
  import cci_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int MDATA_W = 16
);
  localparam int TAG_W = tag_width(NUM_REQ, MDATA_W);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_available;
  logic                      out_en;
  logic [ADDR_W-1:0]         out_addr;
  logic [MDATA_W-1:0]        out_mdata;
  logic                      resp_valid;
  logic [511:0]              resp_data;
  logic [MDATA_W-1:0]        resp_mdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [511:0]              rsp_data;
  logic [TAG_W-1:0]          rsp_tag;
  logic                      busy;
  logic                      err;

  modport slave (
    input  req_valid, req_addr, req_tag, out_available, resp_valid, resp_data, resp_mdata,
    output req_ready, out_en, out_addr, out_mdata, rsp_valid, rsp_data, rsp_tag, busy, err
  );

  modport master (
    output req_valid, req_addr, req_tag, out_available, resp_valid, resp_data, resp_mdata,
    input  req_ready, out_en, out_addr, out_mdata, rsp_valid, rsp_data, rsp_tag, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/cci_rd_arbiter_rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_priority_pick: one-hot pick of first eligible bit at/after ptr    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);
  logic found;

  // Outer loop walks the rotated search order; exactly one i matches each k.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && elig[i] && (((int'(ptr) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/cci_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cci_rd_arbiter: round-robin read merge with id-based response route  |
// | Optional grant statistics: CCI_RD_ARB_STATS_EN. Revision: 1.0         |
// +----------------------------------------------------------------------+
module cci_rd_arbiter
  import cci_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int MDATA_W = 16,
  parameter int MAX_OUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef CCI_RD_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]  grant_cnt,
`endif
  cci_rd_arbiter_if.slave        bus
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int TAG_W = tag_width(NUM_REQ, MDATA_W);
  localparam int CNT_W = cnt_width(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [ID_W-1:0]    p_q, p_d;
  logic [CNT_W-1:0]   outst_q [NUM_REQ];
  logic [CNT_W-1:0]   outst_d [NUM_REQ];
  logic               out_en_q, out_en_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic [MDATA_W-1:0] out_mdata_q, out_mdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [511:0]       rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] elig, pick, grant, resp_hit, nonzero;
  logic [ID_W-1:0]    gnt_idx, resp_id;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [TAG_W-1:0]   gnt_tag;
  logic               id_ok, underflow;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (outst_q[i] != CNT_MAX);
    end
  end

  rr_priority_pick #(.N(NUM_REQ), .PTR_W(ID_W)) u_pick (
    .elig (elig),
    .ptr  (p_q),
    .gnt  (pick)
  );

  // Reset masks the grant so nothing can transfer during the reset cycle.
  assign grant         = (rst_n && bus.out_available) ? pick : '0;
  assign bus.req_ready = grant;

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx  |= ID_W'(i);
        gnt_addr |= bus.req_addr[i*ADDR_W +: ADDR_W];
        gnt_tag  |= bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign resp_id = ID_W'(mdata_id(32'(bus.resp_mdata), MDATA_W, ID_W));
  assign id_ok   = (32'(resp_id) < 32'(NUM_REQ));

  always_comb begin
    resp_hit  = '0;
    underflow = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_hit[i] = bus.resp_valid && id_ok && (resp_id == ID_W'(i));
      if (resp_hit[i] && (outst_q[i] == '0)) underflow = 1'b1;
    end
  end

  // A grant and a response for the same requester in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      outst_d[i] = outst_q[i];
      if (grant[i] && !resp_hit[i]) begin
        outst_d[i] = outst_q[i] + CNT_W'(1);
      end else if (resp_hit[i] && !grant[i] && (outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] - CNT_W'(1);
      end
      nonzero[i] = (outst_q[i] != '0);
    end
  end

  always_comb begin
    p_d = p_q;
    if (|grant) p_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    out_en_d    = |grant;
    out_addr_d  = (|grant) ? gnt_addr : out_addr_q;
    out_mdata_d = (|grant) ? MDATA_W'(mdata_pack(32'(gnt_idx), 32'(gnt_tag), TAG_W))
                           : out_mdata_q;
    rsp_valid_d = resp_hit;
    rsp_data_d  = bus.resp_valid ? bus.resp_data : rsp_data_q;
    rsp_tag_d   = bus.resp_valid ? TAG_W'(mdata_tag(32'(bus.resp_mdata), TAG_W)) : rsp_tag_q;
    err_d       = err_q | (bus.resp_valid && (!id_ok || underflow));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_en_q    <= 1'b0;
      out_addr_q  <= '0;
      out_mdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      p_q         <= p_d;
      out_en_q    <= out_en_d;
      out_addr_q  <= out_addr_d;
      out_mdata_q <= out_mdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign bus.out_en    = out_en_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_mdata = out_mdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.err       = err_q;
  assign bus.busy      = |nonzero;

`ifdef CCI_RD_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_REQ];
  logic [31:0] gcnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gcnt_d[i] = (grant[i] && (gcnt_q[i] != '1)) ? gcnt_q[i] + 32'd1 : gcnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    assign grant_cnt[g*32 +: 32] = gcnt_q[g];
  end
`endif
endmodule
`default_nettype wire
